product_bcd_converter: RTL

PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

---
 rtl/product_bcd_converter_pkg.sv | 17 +
 rtl/product_bcd_converter_if.sv | 33 +++
 rtl/product_bcd_converter_digit_adjust.sv | 9 +
 rtl/product_bcd_converter.sv | 94 +++++++++
 4 files changed

// File: rtl/product_bcd_converter_pkg.sv
// rtl/product_bcd_converter_pkg.sv - shared types, defaults and sizing helpers for the product BCD converter
package product_bcd_converter_pkg;

  localparam int DEFAULT_WORD_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(bits * log10(2)), with log10(2) taken as 0.30103
  function automatic int bcd_digits(input int bits);
    return (bits * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/product_bcd_converter_if.sv
// rtl/product_bcd_converter_if.sv - request/result bundle between a producer and the BCD converter
interface product_bcd_converter_if
  import product_bcd_converter_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) ();

  localparam int IN_WIDTH = 2 * WORD_LENGTH;
  localparam int DIGITS   = bcd_digits(IN_WIDTH);

  logic                  Start;
  logic [IN_WIDTH-1:0]   Binary_In;
  logic                  busy;
  logic                  ready;
  logic [4*DIGITS-1:0]   BCD_Out;

  modport master (
    output Start,
    output Binary_In,
    input  busy,
    input  ready,
    input  BCD_Out
  );

  modport slave (
    input  Start,
    input  Binary_In,
    output busy,
    output ready,
    output BCD_Out
  );

endinterface

// File: rtl/product_bcd_converter_digit_adjust.sv
// rtl/product_bcd_converter_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - sequential double-dabble converter turning a binary product into packed BCD
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                     clk,
  input  logic                     reset,
  product_bcd_converter_if.slave   bus
);

  localparam int IN_WIDTH = 2 * WORD_LENGTH;
  localparam int DIGITS   = bcd_digits(IN_WIDTH);
  localparam int BCD_W    = 4 * DIGITS;
  localparam int CNT_W    = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [BCD_W-1:0]      r_scratch;
  logic [BCD_W-1:0]      w_scratch_nxt;
  logic [BCD_W-1:0]      r_bcd_out;
  logic [BCD_W-1:0]      w_bcd_out_nxt;
  logic [BCD_W-1:0]      w_adj;
  logic [IN_WIDTH-1:0]   r_shift;
  logic [IN_WIDTH-1:0]   w_shift_nxt;
  logic [BCD_W+IN_WIDTH-1:0] w_shifted;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_digit (r_scratch[4*g +: 4]),
        .o_digit (w_adj[4*g +: 4])
      );
    end
  endgenerate

  // Corrected scratch and the binary shift register move left together as one word
  assign w_shifted = {w_adj, r_shift} << 1;

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_scratch_nxt = r_scratch;
    w_shift_nxt   = r_shift;
    w_bcd_out_nxt = r_bcd_out;
    case (r_state)
      IDLE, DONE: begin
        if (bus.Start) begin
          w_state_nxt   = SHIFT;
          w_shift_nxt   = bus.Binary_In;
          w_scratch_nxt = '0;
          w_count_nxt   = '0;
        end
      end
      SHIFT: begin
        if (r_count == LAST_CNT) begin
          w_state_nxt   = DONE;
          w_bcd_out_nxt = r_scratch;
        end else begin
          w_scratch_nxt = w_shifted[BCD_W+IN_WIDTH-1:IN_WIDTH];
          w_shift_nxt   = w_shifted[IN_WIDTH-1:0];
          w_count_nxt   = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_scratch <= '0;
      r_shift   <= '0;
      r_bcd_out <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_scratch <= w_scratch_nxt;
      r_shift   <= w_shift_nxt;
      r_bcd_out <= w_bcd_out_nxt;
    end
  end

  assign bus.busy    = (r_state == SHIFT);
  assign bus.ready   = (r_state == DONE);
  assign bus.BCD_Out = r_bcd_out;

endmodule
